// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants for the 1x3 packet router datapath.
//   DATA_W        byte width of the router data bus
//   ADDR_W        width of the destination address field in the header
//   ADDR_INVALID  address code that does not select any output port
//   HDR_*         bit positions of the header fields {len, addr}
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Header layout: {len[7:2], addr[1:0]}
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    // True when the header address selects one of the three output ports.
    function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_reg.sv
// ---------------------------------------------------------------------------
// router_reg
// Datapath register block of the 1x3 packet router. Latches the packet
// header, forwards header/payload/parity bytes to the FIFO bus one clock
// after they arrive, holds a byte that arrives while the FIFO is full and
// replays it later, and checks the packet parity byte against a running XOR.
//
// Ports
//   clock             in   single clock, all state updates on posedge
//   resetn            in   synchronous reset, active high (1 = reset)
//   pkt_valid         in   source byte valid, low while parity byte is sent
//   data_in           in   header / payload / parity byte
//   fifo_full         in   selected FIFO is full
//   detect_add        in   FSM: header is on data_in
//   ld_state          in   FSM: loading payload / parity
//   laf_state         in   FSM: load-after-full, replay the held byte
//   full_state        in   FSM: waiting on a full FIFO
//   lfd_state         in   FSM: load first data (header into FIFO)
//   rst_int_reg       in   FSM: clear low_packet_valid
//   err               out  parity mismatch flag
//   parity_done       out  parity byte has been captured
//   low_packet_valid  out  pkt_valid fell while loading
//   dout              out  byte to the FIFOs
//
// Configuration
//   ROUTER_REG_PARITY_CHECK_EN  when defined, the running parity, the
//   captured packet parity and the err flag are built; otherwise those
//   registers are left out and err is tied low.
// ---------------------------------------------------------------------------
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              lfd_state,
    input  logic              rst_int_reg,
    output logic              err,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] header_byte_q,     header_byte_d;
    logic [DATA_W-1:0] full_state_byte_q, full_state_byte_d;
    logic [DATA_W-1:0] dout_q,            dout_d;
    logic              parity_done_q,     parity_done_d;
    logic              low_pkt_valid_q,   low_pkt_valid_d;

    // Next-state logic for the header/data path and the FSM status flags.
    // Each register holds unless one of its conditions fires.
    always_comb begin
        header_byte_d     = header_byte_q;
        full_state_byte_d = full_state_byte_q;
        dout_d            = dout_q;
        parity_done_d     = parity_done_q;
        low_pkt_valid_d   = low_pkt_valid_q;

        // A header with the invalid address is dropped, so lfd_state later
        // re-sends whichever valid header was latched before it.
        if (detect_add && pkt_valid &&
            addr_is_valid(data_in[HDR_ADDR_MSB:HDR_ADDR_LSB])) begin
            header_byte_d = data_in;
        end

        if (lfd_state) begin
            dout_d = header_byte_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (laf_state) begin
            dout_d = full_state_byte_q;
        end

        // Byte that could not be written because the FIFO was full.
        if (ld_state && fifo_full) begin
            full_state_byte_d = data_in;
        end

        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end

        // The second set term covers a parity byte that arrived while the
        // FIFO was full and is only written during the replay.
        if (detect_add) begin
            parity_done_d = 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            header_byte_q     <= '0;
            full_state_byte_q <= '0;
            dout_q            <= '0;
            parity_done_q     <= 1'b0;
            low_pkt_valid_q   <= 1'b0;
        end else begin
            header_byte_q     <= header_byte_d;
            full_state_byte_q <= full_state_byte_d;
            dout_q            <= dout_d;
            parity_done_q     <= parity_done_d;
            low_pkt_valid_q   <= low_pkt_valid_d;
        end
    end

`ifdef ROUTER_REG_PARITY_CHECK_EN
    logic [DATA_W-1:0] internal_parity,    internal_parity_d;
    logic [DATA_W-1:0] packet_parity_byte, packet_parity_byte_d;
    logic              err_q,              err_d;

    // Running XOR over header and payload, the received parity byte, and
    // the comparison result. err is re-evaluated every cycle parity_done is
    // high, so it settles one clock after parity_done rises.
    always_comb begin
        internal_parity_d    = internal_parity;
        packet_parity_byte_d = packet_parity_byte;
        err_d                = err_q;

        if (detect_add) begin
            internal_parity_d = '0;
        end else if (lfd_state) begin
            internal_parity_d = internal_parity ^ header_byte_q;
        end else if (ld_state && pkt_valid && !full_state) begin
            internal_parity_d = internal_parity ^ data_in;
        end

        if (detect_add) begin
            packet_parity_byte_d = '0;
        end else if (ld_state && !pkt_valid) begin
            packet_parity_byte_d = data_in;
        end

        if (parity_done_q) begin
            err_d = (internal_parity != packet_parity_byte);
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            internal_parity    <= '0;
            packet_parity_byte <= '0;
            err_q              <= 1'b0;
        end else begin
            internal_parity    <= internal_parity_d;
            packet_parity_byte <= packet_parity_byte_d;
            err_q              <= err_d;
        end
    end

    assign err = err_q;
`else
    // Without the parity checker full_state has no consumer.
    logic unused_full_state;
    assign unused_full_state = full_state;

    assign err = 1'b0;
`endif

    assign dout             = dout_q;
    assign parity_done      = parity_done_q;
    assign low_packet_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// ---------------------------------------------------------------------------
// tb_router_reg
// Directed self-checking bench for router_reg: reset values, a good packet,
// a packet with a corrupted parity byte, an invalid-address header, the
// FIFO-full hold/replay path and a mid-stream reset.
// ---------------------------------------------------------------------------
module tb_router_reg;

    localparam int DATA_W = 8;
    localparam int N_PAYLOAD = 14;

    logic              clock;
    logic              resetn;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              detect_add;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              lfd_state;
    logic              rst_int_reg;
    logic              err;
    logic              parity_done;
    logic              low_packet_valid;
    logic [DATA_W-1:0] dout;

    int total_count;
    int bad_count;

    logic [DATA_W-1:0] payload [N_PAYLOAD];
    logic [DATA_W-1:0] exp_parity;

    router_reg #(.DATA_W(DATA_W)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .lfd_state        (lfd_state),
        .rst_int_reg      (rst_int_reg),
        .err              (err),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .dout             (dout)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one cycle's worth of inputs, then advances to just after the
    // next rising edge so outputs can be sampled away from the edge.
    task automatic applyStimulus(
        input logic              rst,
        input logic              da,
        input logic              lfd,
        input logic              ld,
        input logic              laf,
        input logic              fst,
        input logic              ff,
        input logic              pv,
        input logic              rir,
        input logic [DATA_W-1:0] din
    );
        resetn      = rst;
        detect_add  = da;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fst;
        fifo_full   = ff;
        pkt_valid   = pv;
        rst_int_reg = rir;
        data_in     = din;
        @(posedge clock);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends header 0x39, the payload table and a parity byte (optionally
    // inverted), checking dout one clock behind each byte.
    task automatic sendPacket(input logic corrupt);
        logic [DATA_W-1:0] pbyte;
        pbyte = corrupt ? ~exp_parity : exp_parity;

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h39);
        checkOutput("hdr_pd_clear", parity_done, 0);
`ifdef ROUTER_REG_PARITY_CHECK_EN
        checkOutput("hdr_ip_clear", dut.internal_parity, 0);
`endif
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
        checkOutput("lfd_dout", dout, 8'h39);

        for (int i = 0; i < N_PAYLOAD; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, payload[i]);
            checkOutput($sformatf("pay%0d_dout", i), dout, payload[i]);
        end

        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, pbyte);
        checkOutput("par_dout", dout, pbyte);
        checkOutput("par_pd", parity_done, 1);
        checkOutput("par_lpv", low_packet_valid, 1);
`ifdef ROUTER_REG_PARITY_CHECK_EN
        checkOutput("par_err_before", err, 0);
        checkOutput("par_ip", dut.internal_parity, exp_parity);
        checkOutput("par_ppb", dut.packet_parity_byte, pbyte);
`endif
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;

        payload = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
                    8'hF0, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};
        exp_parity = 8'h39;
        for (int i = 0; i < N_PAYLOAD; i++) exp_parity ^= payload[i];

        // Reset with all FSM inputs idle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_pd", parity_done, 0);
        checkOutput("rst_lpv", low_packet_valid, 0);

        // Good packet; err is evaluated one clock after parity_done.
        sendPacket(1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("good_err", err, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("good_err_hold", err, 0);
        checkOutput("good_pd_hold", parity_done, 1);

        // rst_int_reg clears low_packet_valid only.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        checkOutput("rir_lpv", low_packet_valid, 0);
        checkOutput("rir_pd", parity_done, 1);

        // Bad packet: inverted parity byte raises err, which then holds.
        sendPacket(1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
`ifdef ROUTER_REG_PARITY_CHECK_EN
        checkOutput("bad_err", err, 1);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
`ifdef ROUTER_REG_PARITY_CHECK_EN
        checkOutput("bad_err_hold", err, 1);
`endif

        // Invalid address header is not latched; lfd re-sends 0x39.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h3B);
        checkOutput("inv_pd_clear", parity_done, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
        checkOutput("inv_lfd_dout", dout, 8'h39);
`ifdef ROUTER_REG_PARITY_CHECK_EN
        checkOutput("inv_err_hold", err, 1);
`endif

        // FIFO full: byte is held, dout unchanged, then replayed in laf.
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 1, 0, 8'hA5);
        checkOutput("full_dout_hold", dout, 8'h39);
        checkOutput("full_pd", parity_done, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00);
        checkOutput("laf_dout", dout, 8'hA5);
        // low_packet_valid is still set from the bad packet, so the replay
        // cycle also marks parity_done.
        checkOutput("laf_pd", parity_done, 1);

        // Reset in the middle of activity returns everything to zero.
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 1, 0, 8'h77);
        checkOutput("mid_rst_dout", dout, 0);
        checkOutput("mid_rst_err", err, 0);
        checkOutput("mid_rst_pd", parity_done, 0);
        checkOutput("mid_rst_lpv", low_packet_valid, 0);

        // Header after reset restarts cleanly.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h39);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
        checkOutput("restart_dout", dout, 8'h39);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
